// File: rtl/shared_bus_pkg.sv
// Shared types for the bus transfer block that sits behind the 2-master arbiter.
package shared_bus_pkg;
  typedef enum logic [1:0] {IDLE, XFER, DONE, RELEASE} xfer_state_t;
  localparam logic [1:0] GRANT_M0 = 2'b01;
  localparam logic [1:0] GRANT_M1 = 2'b10;
  typedef logic owner_t;
endpackage

// File: rtl/xfer_beat_counter.sv
// Beat counter for one granted burst; last flags the final beat of the burst.
module xfer_beat_counter #(
  parameter int BURST_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);
  localparam int CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (inc)   cnt <= cnt + 1'b1;
  end

  assign last = (cnt == LAST_CNT);
endmodule

// File: rtl/shared_bus_xfer.sv
// Owns the shared bus for the granted master, counts a fixed burst, then
// pulses done (or abort on grant loss) and releases the bus for one cycle.
module shared_bus_xfer
  import shared_bus_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        grant,
  input  logic              valid0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              valid1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              bus_ready,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic [1:0]        done,
  output logic              abort,
  output logic              err,
  output logic              busy
);
  xfer_state_t state;
  owner_t      owner;
  logic        granted;
  logic        beat;
  logic        last;
  logic        clear;
  logic        inc;

  assign granted   = grant[owner];
  assign bus_valid = (state == XFER) && (owner ? valid1 : valid0);
  assign bus_data  = bus_valid ? (owner ? wdata1 : wdata0) : '0;
  assign beat      = bus_valid && bus_ready;
  assign busy      = (state != IDLE);

  // A beat in the same cycle as a grant loss is not counted.
  assign clear = (state == IDLE);
  assign inc   = (state == XFER) && granted && beat;

  xfer_beat_counter #(
    .BURST_LEN(BURST_LEN)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .inc  (inc),
    .last (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      done  <= 2'b00;
      abort <= 1'b0;
      err   <= 1'b0;
    end else begin
      done  <= 2'b00;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (grant == GRANT_M0) begin
            owner <= 1'b0;
            state <= XFER;
          end else if (grant == GRANT_M1) begin
            owner <= 1'b1;
            state <= XFER;
          end else if (grant == 2'b11) begin
            err <= 1'b1;
          end
        end
        XFER: begin
          if (!granted) begin
            abort <= 1'b1;
            state <= RELEASE;
          end else if (beat && last) begin
            done[owner] <= 1'b1;
            state       <= DONE;
          end
        end
        DONE:    state <= RELEASE;
        // Covers the arbiter's registered lag after the request drops.
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
